// File: rtl/alu_pkg.sv
// Shared ALU op encodings, requester id type and output-slot FSM states.
package alu_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ADD = 4'd0;
    localparam alu_op_t SUB = 4'd1;
    localparam alu_op_t OR  = 4'd9;
    localparam alu_op_t AND = 4'd10;

    // Index of a requester (two requesters share the ALU).
    typedef logic req_id_t;

    typedef enum logic {StEmpty, StFull} slot_state_t;

endpackage

// File: rtl/alu.sv
// Purely combinational ALU; unsupported op codes yield zero, arithmetic wraps.
module alu
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic [3:0]   op,
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic [n-1:0] y
);

    // Decode the op code into the selected result.
    always_comb begin
        y = '0;
        case (op)
            ADD:     y = a + b;
            SUB:     y = a - b;
            OR:      y = a | b;
            AND:     y = a & b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two requesters share one ALU through a round-robin grant and a one-entry
// registered result slot (EMPTY/FULL) with valid/ready on both sides.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned n = 32
) (
    input  logic         clk,
    input  logic         reset,

    input  logic         req0_valid,
    input  logic [3:0]   req0_op,
    input  logic [n-1:0] req0_a,
    input  logic [n-1:0] req0_b,
    output logic         req0_ready,

    input  logic         req1_valid,
    input  logic [3:0]   req1_op,
    input  logic [n-1:0] req1_a,
    input  logic [n-1:0] req1_b,
    output logic         req1_ready,

    output logic         resp_valid,
    output logic         resp_id,
    output logic [n-1:0] resp_data,
    input  logic         resp_ready
);

    slot_state_t  state_q, state_d;
    req_id_t      rr_q;
    req_id_t      resp_id_q;
    logic [n-1:0] resp_data_q;

    logic         both;
    logic         any;
    logic         free;
    logic         handshake;
    req_id_t      gnt_id;
    alu_op_t      alu_op;
    logic [n-1:0] alu_a;
    logic [n-1:0] alu_b;
    logic [n-1:0] alu_y;

    // Grant and ready: independent of operands, forced low during reset.
    always_comb begin
        both      = req0_valid & req1_valid;
        any       = req0_valid | req1_valid;
        free      = (state_q == StEmpty) | resp_ready;
        gnt_id    = both ? rr_q : req_id_t'(req1_valid);
        handshake = free & any & ~reset;
        req0_ready = handshake & (gnt_id == 1'b0);
        req1_ready = handshake & (gnt_id == 1'b1);
        alu_op    = gnt_id ? req1_op : req0_op;
        alu_a     = gnt_id ? req1_a  : req0_a;
        alu_b     = gnt_id ? req1_b  : req0_b;
    end

    alu #(
        .n (n)
    ) u_alu (
        .op (alu_op),
        .a  (alu_a),
        .b  (alu_b),
        .y  (alu_y)
    );

    // Slot next state: a handshake always refills; a drained slot with no new grant empties.
    always_comb begin
        state_d = state_q;
        if (handshake) begin
            state_d = StFull;
        end else if ((state_q == StFull) && resp_ready) begin
            state_d = StEmpty;
        end
    end

    // Slot state, held result and round-robin pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StEmpty;
            resp_data_q <= '0;
            resp_id_q   <= 1'b0;
            rr_q        <= 1'b0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                resp_data_q <= alu_y;
                resp_id_q   <= gnt_id;
                // Only contended grants move the pointer, to favour the loser next time.
                if (both) begin
                    rr_q <= ~gnt_id;
                end
            end
        end
    end

    assign resp_valid = (state_q == StFull);
    assign resp_id    = resp_id_q;
    assign resp_data  = resp_data_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: stimulus pushes expected results into a
// scoreboard queue; a monitor pops and compares on each consumed response.
module tb_alu_arbiter;

    localparam int N = 32;

    typedef struct packed {
        logic         id;
        logic [N-1:0] data;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         req0_valid, req1_valid;
    logic [3:0]   req0_op, req1_op;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         req0_ready, req1_ready;
    logic         resp_valid, resp_id, resp_ready;
    logic [N-1:0] resp_data;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    logic         hold_pending = 1'b0;
    logic [N-1:0] held_data;
    logic         held_id;

    alu_arbiter #(.n(N)) dut (
        .clk        (clk),
        .reset      (reset),
        .req0_valid (req0_valid),
        .req0_op    (req0_op),
        .req0_a     (req0_a),
        .req0_b     (req0_b),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_op    (req1_op),
        .req1_a     (req1_a),
        .req1_b     (req1_b),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_data  (resp_data),
        .resp_ready (resp_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] model(input logic [3:0] op, input logic [N-1:0] a,
                                           input logic [N-1:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd9:    return a | b;
            4'd10:   return a & b;
            default: return '0;
        endcase
    endfunction

    task automatic chk(input string name, input logic [N-1:0] got, input logic [N-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
        end
    endtask

    // One clock of stimulus; exp_gnt = -1 means no grant is expected this cycle.
    task automatic cycle(input logic v0, input logic [3:0] op0, input logic [N-1:0] a0,
                         input logic [N-1:0] b0, input logic v1, input logic [3:0] op1,
                         input logic [N-1:0] a1, input logic [N-1:0] b1, input logic rdy,
                         input int exp_gnt);
        exp_t e;
        req0_valid = v0; req0_op = op0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_op = op1; req1_a = a1; req1_b = b1;
        resp_ready = rdy;
        @(negedge clk);
        chk("req0_ready", N'(req0_ready), N'(exp_gnt == 0));
        chk("req1_ready", N'(req1_ready), N'(exp_gnt == 1));
        @(posedge clk);
        if (exp_gnt == 0) begin
            e.id = 1'b0; e.data = model(op0, a0, b0); sb.push_back(e);
        end else if (exp_gnt == 1) begin
            e.id = 1'b1; e.data = model(op1, a1, b1); sb.push_back(e);
        end
        #1;
    endtask

    task automatic idle(input logic rdy);
        cycle(1'b0, 4'd0, '0, '0, 1'b0, 4'd0, '0, '0, rdy, -1);
    endtask

    // Monitor: consume/compare responses, check latency, mutual exclusion and hold stability.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            checks++;
            if (req0_ready && req1_ready) begin
                errors++;
                $display("FAIL ready_excl: both req0_ready and req1_ready high");
            end
            if (hold_pending) begin
                checks++;
                if (!resp_valid || resp_data !== held_data || resp_id !== held_id) begin
                    errors++;
                    $display("FAIL hold_stable: got v=%0b id=%0b 0x%0h expected v=1 id=%0b 0x%0h",
                             resp_valid, resp_id, resp_data, held_id, held_data);
                end
            end
            if (sb.size() > 0 && !resp_valid) begin
                checks++;
                errors++;
                $display("FAIL latency: resp_valid=0 with %0d result(s) outstanding", sb.size());
            end
            if (resp_valid && resp_ready) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_resp: id=%0b data=0x%0h, none expected",
                             resp_id, resp_data);
                end else begin
                    e = sb.pop_front();
                    if (resp_id !== e.id || resp_data !== e.data) begin
                        errors++;
                        $display("FAIL resp: got id=%0b 0x%0h expected id=%0b 0x%0h",
                                 resp_id, resp_data, e.id, e.data);
                    end
                end
            end
        end
        hold_pending = resp_valid && !resp_ready && !reset;
        held_data    = resp_data;
        held_id      = resp_id;
    end

    initial begin
        reset = 1'b1;
        resp_ready = 1'b0;
        req0_valid = 1'b1; req0_op = 4'd0; req0_a = 32'd1; req0_b = 32'd1;
        req1_valid = 1'b1; req1_op = 4'd0; req1_a = 32'd1; req1_b = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready0_in_reset", N'(req0_ready), '0);
        chk("ready1_in_reset", N'(req1_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("rst_resp_valid", N'(resp_valid), '0);
        chk("rst_resp_id", N'(resp_id), '0);
        chk("rst_resp_data", resp_data, '0);
        @(posedge clk); #1;

        // Single request: 5 + 7 from requester 0.
        cycle(1'b1, 4'd0, 32'd5, 32'd7, 1'b0, 4'd0, '0, '0, 1'b1, 0);
        idle(1'b1);

        // Contention, back-to-back: grants alternate 0,1,0,1.
        for (int i = 0; i < 4; i++)
            cycle(1'b1, 4'd1, 32'd10, 32'd3, 1'b1, 4'd10, 32'hF0, 32'h3C, 1'b1, i % 2);
        idle(1'b1);

        // Backpressure: fill slot, hold it three cycles, then drain and accept req1 together.
        cycle(1'b1, 4'd0, 32'd1, 32'd2, 1'b0, 4'd0, '0, '0, 1'b0, 0);
        for (int i = 0; i < 3; i++)
            cycle(1'b0, 4'd0, '0, '0, 1'b1, 4'd9, 32'h0F, 32'hF0, 1'b0, -1);
        cycle(1'b0, 4'd0, '0, '0, 1'b1, 4'd9, 32'h0F, 32'hF0, 1'b1, 1);
        idle(1'b1);

        // Wraparound and unsupported op.
        cycle(1'b1, 4'd0, 32'hFFFF_FFFF, 32'd1, 1'b0, 4'd0, '0, '0, 1'b1, 0);
        cycle(1'b0, 4'd0, '0, '0, 1'b1, 4'd5, 32'd3, 32'd4, 1'b1, 1);
        idle(1'b1);

        // Reset mid-operation: contended grant to 0 moves rr to 1, then reset discards it.
        cycle(1'b1, 4'd0, 32'd4, 32'd4, 1'b1, 4'd0, 32'd8, 32'd8, 1'b0, 0);
        idle(1'b0);
        reset = 1'b1;
        sb.delete();
        req0_valid = 1'b1; req1_valid = 1'b1;
        @(negedge clk);
        chk("ready0_mid_reset", N'(req0_ready), '0);
        chk("ready1_mid_reset", N'(req1_ready), '0);
        @(posedge clk); #1;
        reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        chk("mid_rst_resp_valid", N'(resp_valid), '0);
        chk("mid_rst_resp_data", resp_data, '0);
        chk("mid_rst_resp_id", N'(resp_id), '0);
        @(posedge clk); #1;
        cycle(1'b1, 4'd0, 32'd1, 32'd1, 1'b1, 4'd1, 32'd9, 32'd2, 1'b1, 0);
        idle(1'b1);
        idle(1'b1);

        chk("scoreboard_drained", N'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: n, 32, operand/result width in bits.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 req0_valid  input  1  requester 0 presents an operation.
REQ-005 req0_op  input  4  AluOp code for requester 0.
REQ-006 req0_a, req0_b  input  n  operands for requester 0.
REQ-007 req0_ready  output  1  requester 0 request accepted this cycle when high with req0_valid.
REQ-008 req1_valid, req1_op, req1_a, req1_b, req1_ready: same as REQ-004..007 for requester 1.
REQ-009 resp_valid  output  1  result register holds a valid result.
REQ-010 resp_id  output  1  index of the requester that issued the held result.
REQ-011 resp_data  output  n  held ALU result.
REQ-012 resp_ready  input  1  consumer accepts the result this cycle.

Function
REQ-013 SHALL share one internal ALU instance between two requesters; AluOp passes through unmodified (0 ADD, 1 SUB, 9 OR, 10 AND, others yield 0).
REQ-014 Output FSM SHALL have two states: EMPTY (resp_valid=0) and FULL (resp_valid=1).
REQ-015 Slot free condition: free = (state==EMPTY) or resp_ready.
REQ-016 Grant: only one valid -> that requester; both valid -> requester selected by round-robin pointer rr; neither -> no grant.
REQ-017 reqX_ready SHALL be high only when free and requester X holds the grant; never both high in one cycle.
REQ-018 reqX_ready SHALL depend only on state, resp_ready, req valids and rr (no operand dependency).
REQ-019 On a handshake, the granted op/operands drive the ALU combinationally; result captured into resp_data, id into resp_id at that clock edge.
REQ-020 Latency: result visible on resp_data/resp_valid exactly one cycle after the accepting edge.
REQ-021 Transitions: EMPTY + grant -> FULL; FULL + resp_ready + grant -> FULL (back-to-back, new result); FULL + resp_ready + no grant -> EMPTY; FULL + !resp_ready -> FULL, resp_data/resp_id stable.
REQ-022 rr SHALL update only on a handshake when both requesters were valid: rr <= ~granted_id; single-requester grants leave rr unchanged.
REQ-023 Throughput: one operation per cycle sustained while resp_ready stays high.
REQ-024 Arithmetic wraps modulo 2^n; no flags output.
REQ-025 A requester dropping valid without handshake SHALL leave no state change.

Reset
REQ-026 On reset at a clock edge: state=EMPTY, resp_valid=0, resp_id=0, resp_data=0, rr=0 (requester 0 favoured first).
REQ-027 Reset mid-operation SHALL discard a held unconsumed result; reqX_ready SHALL be 0 while reset is high.

Structure
REQ-028 Shared package alu_pkg SHALL hold AluOp encoding constants (ADD, SUB, OR, AND) and the 1-bit requester-id type.
REQ-029 SHALL instantiate the existing alu module as its single sub-module, parameter n forwarded.
REQ-030 Output register and FSM SHALL be in one clocked process; grant logic combinational.

Verification
REQ-031 Single request: reset, req0 valid op=0 A=5 B=7, resp_ready=1 -> req0_ready=1; next cycle resp_valid=1, resp_id=0, resp_data=12.
REQ-032 Contention: both valid every cycle, req0 op=1 A=10 B=3, req1 op=10 A=0xF0 B=0x3C, resp_ready=1 -> grants alternate 0,1,0,1; results 7, 0x30, 7, 0x30.
REQ-033 Backpressure: FULL with resp_ready=0 for 3 cycles, req1 valid -> req1_ready=0 throughout, resp_data unchanged; resp_ready=1 -> req1 accepted same cycle, new result next cycle.
REQ-034 Wrap/invalid op: op=0 A=0xFFFFFFFF B=1 -> resp_data=0; op=5 A=3 B=4 -> resp_data=0.
REQ-035 Reset mid-operation: FULL with resp_ready=0, assert reset one cycle -> resp_valid=0, resp_data=0, rr=0; next contention grants requester 0.
REQ-036 Bench SHALL assert never both reqX_ready high and resp_data stable whenever resp_valid & !resp_ready.
